// File: rtl/fp16_pkg.sv
// fp16_pkg: shared FP16 constants and activation mode encoding
package fp16_pkg;
  localparam logic [15:0] FP16_ONE = 16'h3C00;
  localparam logic [15:0] FP16_NEG_ONE = 16'hBC00;
  localparam logic [15:0] FP16_QNAN = 16'h7E00;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MANT_W = 10;
  localparam int FP16_BIAS = 15;
  typedef enum logic {ACT_TANH = 1'b0, ACT_SIGMOID = 1'b1} act_mode_e;
endpackage

// File: rtl/fp16_act_lut.sv
// fp16_act_lut: synchronous ROM, bank 0 tanh and bank 1 sigmoid of addr*2^-FRAC_BITS,
// contents computed at elaboration in 2^-30 fixed point so every parameter set gets its own table
module fp16_act_lut #(
  parameter int ADDR_W = 11,
  parameter int FRAC_BITS = 9,
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W:0]   addr,
  output logic [DATA_W-1:0] q
);
  localparam int DEPTH = 2 ** (ADDR_W + 1);
  localparam longint S = longint'(1) << 30;
  function automatic longint exp_frac(input longint f);
    longint term;
    longint sum;
    term = S;
    sum = S;
    for (longint k = 1; k < 24; k++) begin
      term = term * f / ((longint'(1) << FRAC_BITS) * k);
      sum = k[0] ? sum - term : sum + term;
    end
    return sum;
  endfunction
  function automatic longint exp_neg(input longint y);
    longint r;
    longint e1;
    r = exp_frac(y & ((longint'(1) << FRAC_BITS) - 1));
    e1 = exp_frac(longint'(1) << FRAC_BITS);
    for (longint i = 0; i < (y >> FRAC_BITS); i++) r = (r * e1) >> 30;
    return r;
  endfunction
  function automatic logic [DATA_W-1:0] lut_val(input longint idx);
    longint a;
    longint e;
    longint one;
    longint v;
    a = idx & ((longint'(1) << ADDR_W) - 1);
    e = exp_neg(idx[ADDR_W] ? a : 2 * a);
    one = longint'(1) << DATA_W;
    v = ((idx[ADDR_W] ? S : S - e) * one + (S + e) / 2) / (S + e);
    return v >= one ? DATA_W'(one - 1) : DATA_W'(v);
  endfunction
  logic [DATA_W-1:0] rom [DEPTH];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    localparam logic [DATA_W-1:0] V = lut_val(i);
    assign rom[i] = V;
  end
  always_ff @(posedge clk)
    if (en) q <= rom[addr];
endmodule

// File: rtl/fp16_activation_pipe.sv
// fp16_activation_pipe: 4-stage valid/ready FP16 tanh/sigmoid unit with LUT core,
// IEEE special handling and a sticky saturation counter; the whole pipe freezes on stall
module fp16_activation_pipe
  import fp16_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int FRAC_BITS = 9,
  parameter int DATA_W = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] sat_count
);
  localparam int SAT_EXP = FP16_BIAS + ADDR_W - FRAC_BITS;
  localparam int SH0 = FP16_BIAS + FP16_MANT_W - FRAC_BITS;
  localparam logic [DATA_W:0] Q_ONE = {1'b1, {DATA_W{1'b0}}};
  logic adv;
  logic v1, m1;
  logic [15:0] d1;
  logic [FP16_EXP_W-1:0] ex;
  logic nan1, sat1;
  logic [ADDR_W-1:0] addr1;
  int sh;
  logic v2, nan2, sat2, s2, m2;
  logic [DATA_W-1:0] q2;
  logic [DATA_W:0] qp;
  logic v3, spec3, s3;
  logic [15:0] sv3;
  logic [DATA_W:0] q3;
  int p;
  logic [DATA_W:0] norm;
  logic [DATA_W+10:0] mx;
  logic rnd;
  logic [15:0] res;
  assign in_ready = out_ready || !out_valid;
  assign adv = in_ready;
  // magnitude = {1,mant} * 2^(ex-SH0) in units of 2^-FRAC_BITS, truncated
  always_comb begin
    ex = d1[FP16_MANT_W +: FP16_EXP_W];
    sh = int'(ex) - SH0;
    nan1 = &ex && |d1[FP16_MANT_W-1:0];
    sat1 = !nan1 && (&ex || int'(ex) >= SAT_EXP);
    addr1 = ex == '0 ? '0 : ADDR_W'(sh >= 0 ? {22'd1, d1[9:0]} << sh : {22'd1, d1[9:0]} >> -sh);
  end
  fp16_act_lut #(.ADDR_W(ADDR_W), .FRAC_BITS(FRAC_BITS), .DATA_W(DATA_W)) u_lut (
    .clk(clk),
    .en(adv),
    .addr({m1, addr1}),
    .q(q2)
  );
  assign qp = (m2 == ACT_SIGMOID && s2) ? Q_ONE - {1'b0, q2} : {1'b0, q2};
  // normalise so the leading one sits at bit DATA_W, then round the fraction to 10 bits
  always_comb begin
    p = 0;
    for (int i = 0; i <= DATA_W; i++) if (q3[i]) p = i;
    norm = q3 << (DATA_W - p);
    mx = {norm[DATA_W-1:0], 11'd0};
    rnd = mx[DATA_W] && (|mx[DATA_W-1:0] || mx[DATA_W+1]);
    res = !norm[DATA_W] ? {s3, 15'd0} : {s3, 5'(p + FP16_BIAS - DATA_W), mx[DATA_W+10 -: 10]} + 16'(rnd);
  end
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      sat_count <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      d1 <= in_data;
      m1 <= in_mode;
      v2 <= v1;
      nan2 <= nan1;
      sat2 <= sat1;
      s2 <= d1[15];
      m2 <= m1;
      v3 <= v2;
      spec3 <= nan2 || sat2;
      sv3 <= nan2 ? FP16_QNAN : !s2 ? FP16_ONE : m2 == ACT_SIGMOID ? 16'h0000 : FP16_NEG_ONE;
      s3 <= s2 && m2 == ACT_TANH;
      q3 <= qp;
      out_valid <= v3;
      out_data <= spec3 ? sv3 : res;
      if (v1 && sat1 && !(&sat_count)) sat_count <= sat_count + 1'b1;
    end
endmodule

// File: tb/tb_fp16_activation_pipe.sv
// tb_fp16_activation_pipe: directed vectors with hand-computed FP16 results
module tb_fp16_activation_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_mode = 1'b0;
  logic out_ready = 1'b1;
  logic [15:0] in_data = '0;
  logic in_ready, out_valid;
  logic [15:0] out_data;
  logic [15:0] sat_count;
  logic w_in_valid = 1'b0;
  logic w_in_ready, w_out_valid;
  logic [15:0] w_out_data;
  logic [3:0] w_sat;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] vin [16];
  logic vmode [16];
  logic [15:0] vexp [16];
  int vtol [16];

  fp16_activation_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_count(sat_count)
  );

  fp16_activation_pipe #(.CNT_W(4)) u_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(16'h7C00),
    .in_mode(1'b0), .out_valid(w_out_valid), .out_ready(1'b1), .out_data(w_out_data),
    .sat_count(w_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp, input int tol = 0);
    logic [31:0] d;
    d = got > exp ? got - exp : exp - got;
    n_chk++;
    if (d > 32'(tol)) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic set_vec(input int i, input logic [15:0] d, input logic m, input logic [15:0] e, input int t);
    vin[i] = d;
    vmode[i] = m;
    vexp[i] = e;
    vtol[i] = t;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int n, input bit stall);
    int ii, oi, cyc, hold;
    bit stalled, prev_stall;
    logic [15:0] held;
    ii = 0;
    oi = 0;
    cyc = 0;
    hold = 0;
    stalled = 1'b0;
    prev_stall = 1'b0;
    held = '0;
    while (oi < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (stall && !stalled && out_valid) begin
        hold = 3;
        stalled = 1'b1;
      end
      out_ready = hold == 0;
      if (hold > 0) hold--;
      in_valid = ii < n;
      in_data = vin[ii];
      in_mode = vmode[ii];
      #1;
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 0);
        if (prev_stall) check("stall_hold", 32'(out_data), 32'(held));
      end
      prev_stall = out_valid && !out_ready;
      held = out_data;
      if (in_valid && in_ready) ii++;
      if (out_valid && out_ready) begin
        check($sformatf("res%0d_in_%h", oi, vin[oi]), 32'(out_data), 32'(vexp[oi]), vtol[oi]);
        oi++;
      end
    end
    check("drained", oi, n);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int lat, stale;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_sat_count", 32'(sat_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data = 16'h3C00;
    in_mode = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", lat, 4);
    check("tanh_one", 32'(out_data), 32'h3A18, 1);

    do_reset();
    set_vec(0, 16'hC800, 1'b0, 16'hBC00, 0);
    set_vec(1, 16'h7C00, 1'b0, 16'h3C00, 0);
    set_vec(2, 16'hC800, 1'b1, 16'h0000, 0);
    set_vec(3, 16'h7E01, 1'b0, 16'h7E00, 0);
    set_vec(4, 16'h0001, 1'b1, 16'h3800, 0);
    run_vec(5, 1'b0);
    check("sat_after_specials", 32'(sat_count), 3);

    set_vec(0, 16'h3C00, 1'b0, 16'h3A18, 1);
    set_vec(1, 16'h3800, 1'b0, 16'h3765, 1);
    set_vec(2, 16'h0000, 1'b1, 16'h3800, 0);
    set_vec(3, 16'hBC00, 1'b1, 16'h344D, 1);
    set_vec(4, 16'h8000, 1'b0, 16'h8000, 0);
    set_vec(5, 16'h43FF, 1'b0, 16'h3BFF, 1);
    set_vec(6, 16'h4400, 1'b0, 16'h3C00, 0);
    set_vec(7, 16'h3C00, 1'b1, 16'h39D9, 1);
    run_vec(8, 1'b1);
    check("sat_after_stream", 32'(sat_count), 4);

    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 16'hC800;
      in_mode = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("sat_pre_reset", 32'(sat_count), 6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_sat_count", 32'(sat_count), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no_stale_results", stale, 0);

    @(negedge clk);
    w_in_valid = 1'b1;
    repeat (20) @(negedge clk);
    w_in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("wrap_in_ready", 32'(w_in_ready), 1);
    check("wrap_sat_count", 32'(w_sat), 15);
    check("wrap_last_data", 32'(w_out_data), 32'h3C00);
    check("wrap_drained", 32'(w_out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end
endmodule
